// File: rtl/event_encoder_8to3.sv
// Registered 8-to-3 event encoder: rising edges on in_lines are captured into a sticky
// pending set and emitted lowest-index-first as binary codes over a valid/ready slot.
module event_encoder_8to3 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       E,
  input  logic [7:0] in_lines,
  input  logic       out_ready,
  output logic [2:0] code,
  output logic       out_valid,
  output logic [7:0] pending,
  output logic       overflow,
  output logic       busy
);

  logic [7:0] in_d;
  logic [7:0] rise;
  logic [7:0] grant;
  logic [7:0] pending_next;
  logic       load;
  logic [2:0] grant_idx;

  assign rise = in_lines & ~in_d & {8{E}};
  assign load = (|pending) & (~out_valid | out_ready);

  // Two's-complement trick isolates the lowest set bit of pending.
  assign grant = load ? (pending & (~pending + 8'd1)) : 8'd0;

  always_comb begin
    grant_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (pending[i]) grant_idx = 3'(i);
    end
  end

  // A rise on the bit being granted re-arms it as a fresh event.
  assign pending_next = (pending & ~grant) | rise;
  assign busy         = (|pending) | out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_d      <= 8'd0;
      pending   <= 8'd0;
      code      <= 3'd0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      in_d    <= in_lines;
      pending <= pending_next;
      if (|(rise & pending & ~grant)) overflow <= 1'b1;
      if (load) begin
        code      <= grant_idx;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Self-checking bench for event_encoder_8to3: directed vector table, hand sequences for
// grant-cycle rise / pending-full / async reset, and a randomized run against a reference model.
module tb_event_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic       E;
  logic [7:0] in_lines;
  logic       out_ready;
  logic [2:0] code;
  logic       out_valid;
  logic [7:0] pending;
  logic       overflow;
  logic       busy;

  int total = 0;
  int bad   = 0;

  event_encoder_8to3 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .E         (E),
    .in_lines  (in_lines),
    .out_ready (out_ready),
    .code      (code),
    .out_valid (out_valid),
    .pending   (pending),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-index event flags and an output slot.
  bit m_prev [8];
  bit m_pend [8];
  bit m_valid;
  int m_code;
  bit m_ovf;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_prev[i] = 0;
      m_pend[i] = 0;
    end
    m_valid = 0;
    m_code  = 0;
    m_ovf   = 0;
  endtask

  task automatic model_edge(input bit e, input logic [7:0] lines, input bit rdy);
    bit rise [8];
    bit any_pend;
    int g;
    any_pend = 0;
    for (int i = 0; i < 8; i++) begin
      rise[i] = e && lines[i] && !m_prev[i];
      if (m_pend[i]) any_pend = 1;
    end
    g = -1;
    if (any_pend && (!m_valid || rdy)) begin
      for (int i = 7; i >= 0; i--) if (m_pend[i]) g = i;
    end
    for (int i = 0; i < 8; i++) begin
      if (rise[i] && m_pend[i] && i != g) m_ovf = 1;
    end
    for (int i = 0; i < 8; i++) begin
      if (i == g) m_pend[i] = 0;
      if (rise[i]) m_pend[i] = 1;
      m_prev[i] = lines[i];
    end
    if (g >= 0) begin
      m_code  = g;
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  function automatic logic [7:0] model_pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] c, input logic v,
                         input logic [7:0] p, input logic o);
    chk({tag, ".code"}, {5'd0, code}, {5'd0, c});
    chk({tag, ".out_valid"}, {7'd0, out_valid}, {7'd0, v});
    chk({tag, ".pending"}, pending, p);
    chk({tag, ".overflow"}, {7'd0, overflow}, {7'd0, o});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, (p != 8'd0) || v});
  endtask

  // Drive inputs, advance one edge (model follows), sample 1 time unit later.
  task automatic step(input bit e, input logic [7:0] lines, input bit rdy);
    E         = e;
    in_lines  = lines;
    out_ready = rdy;
    model_edge(e, lines, rdy);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    E         = 1'b0;
    in_lines  = 8'd0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       e;
    logic [7:0] lines;
    logic       rdy;
    logic [2:0] code;
    logic       vld;
    logic [7:0] pend;
    logic       ovf;
  } vec_t;

  vec_t tbl [36];

  initial begin
    // single event
    tbl[0]  = '{1, 8'h20, 1, 3'd0, 0, 8'h20, 0};
    tbl[1]  = '{1, 8'h00, 1, 3'd5, 1, 8'h00, 0};
    tbl[2]  = '{1, 8'h00, 1, 3'd5, 0, 8'h00, 0};
    // priority ordering 0,1,4,7
    tbl[3]  = '{1, 8'h93, 1, 3'd5, 0, 8'h93, 0};
    tbl[4]  = '{1, 8'h93, 1, 3'd0, 1, 8'h92, 0};
    tbl[5]  = '{1, 8'h93, 1, 3'd1, 1, 8'h90, 0};
    tbl[6]  = '{1, 8'h00, 1, 3'd4, 1, 8'h80, 0};
    tbl[7]  = '{1, 8'h00, 1, 3'd7, 1, 8'h00, 0};
    tbl[8]  = '{1, 8'h00, 1, 3'd7, 0, 8'h00, 0};
    // backpressure
    tbl[9]  = '{1, 8'h08, 0, 3'd7, 0, 8'h08, 0};
    tbl[10] = '{1, 8'h00, 0, 3'd3, 1, 8'h00, 0};
    tbl[11] = '{1, 8'h02, 0, 3'd3, 1, 8'h02, 0};
    tbl[12] = '{1, 8'h00, 0, 3'd3, 1, 8'h02, 0};
    tbl[13] = '{1, 8'h00, 0, 3'd3, 1, 8'h02, 0};
    tbl[14] = '{1, 8'h00, 0, 3'd3, 1, 8'h02, 0};
    tbl[15] = '{1, 8'h00, 1, 3'd1, 1, 8'h00, 0};
    tbl[16] = '{1, 8'h00, 1, 3'd1, 0, 8'h00, 0};
    // enable gating
    tbl[17] = '{0, 8'h00, 1, 3'd1, 0, 8'h00, 0};
    tbl[18] = '{0, 8'h40, 1, 3'd1, 0, 8'h00, 0};
    tbl[19] = '{1, 8'h40, 1, 3'd1, 0, 8'h00, 0};
    tbl[20] = '{1, 8'h00, 1, 3'd1, 0, 8'h00, 0};
    tbl[21] = '{1, 8'h40, 1, 3'd1, 0, 8'h40, 0};
    tbl[22] = '{1, 8'h00, 1, 3'd6, 1, 8'h00, 0};
    tbl[23] = '{1, 8'h00, 1, 3'd6, 0, 8'h00, 0};
    // overflow with slot held
    tbl[24] = '{1, 8'h04, 0, 3'd6, 0, 8'h04, 0};
    tbl[25] = '{1, 8'h00, 0, 3'd2, 1, 8'h00, 0};
    tbl[26] = '{1, 8'h10, 0, 3'd2, 1, 8'h10, 0};
    tbl[27] = '{1, 8'h00, 0, 3'd2, 1, 8'h10, 0};
    tbl[28] = '{1, 8'h10, 0, 3'd2, 1, 8'h10, 1};
    tbl[29] = '{1, 8'h00, 0, 3'd2, 1, 8'h10, 1};
    // bit 0 rises on its own grant edge
    tbl[30] = '{1, 8'h01, 0, 3'd2, 1, 8'h11, 1};
    tbl[31] = '{1, 8'h00, 0, 3'd2, 1, 8'h11, 1};
    tbl[32] = '{1, 8'h01, 1, 3'd0, 1, 8'h11, 1};
    tbl[33] = '{1, 8'h00, 1, 3'd0, 1, 8'h10, 1};
    tbl[34] = '{1, 8'h00, 1, 3'd4, 1, 8'h00, 1};
    tbl[35] = '{1, 8'h00, 1, 3'd4, 0, 8'h00, 1};

    do_reset();
    chk_all("reset", 3'd0, 1'b0, 8'h00, 1'b0);

    for (int r = 0; r < 36; r++) begin
      step(tbl[r].e, tbl[r].lines, tbl[r].rdy);
      chk_all($sformatf("vec%0d", r), tbl[r].code, tbl[r].vld, tbl[r].pend, tbl[r].ovf);
    end

    // Grant-cycle rise must not raise overflow on its own.
    do_reset();
    step(1, 8'h04, 0);
    step(1, 8'h00, 0);
    step(1, 8'h01, 0);
    step(1, 8'h00, 0);
    step(1, 8'h01, 1);
    chk_all("grant_rise", 3'd0, 1'b1, 8'h01, 1'b0);

    // Fill all eight, then rise everything again: pending unchanged, overflow set.
    step(1, 8'hFF, 0);
    chk_all("fill", 3'd0, 1'b1, 8'hFF, 1'b0);
    step(1, 8'h00, 0);
    step(1, 8'hFF, 0);
    chk_all("full_ovf", 3'd0, 1'b1, 8'hFF, 1'b1);

    // Asynchronous reset between edges clears outputs before the next edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 3'd0, 1'b0, 8'h00, 1'b0);

    // Randomized run against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [7:0] lines;
      bit e, rdy;
      e     = ($urandom_range(0, 7) != 0);
      rdy   = ($urandom_range(0, 2) != 0);
      lines = 8'($urandom) & 8'($urandom);
      step(e, lines, rdy);
      chk_all($sformatf("rnd%0d", n), 3'(m_code), m_valid, model_pend_vec(), m_ovf);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
